// File: rtl/dispatch_queue_unit.sv
// In-order decode queue dispatching up to two instructions per cycle to ADD/MUL RS channels.
// Optional macro DQU_PERF_COUNTERS_EN adds stall/dual-dispatch/drop counters.
module dispatch_queue_unit #(
  parameter int                 DEPTH    = 8,
  parameter int                 FIELD_W  = 8,
  parameter logic [FIELD_W-1:0] ADD_CODE = 'h01,
  parameter logic [FIELD_W-1:0] MUL_CODE = 'h02
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid0,
  input  logic [4*FIELD_W-1:0]     in_inst0,
  input  logic                     in_valid1,
  input  logic [4*FIELD_W-1:0]     in_inst1,
  output logic                     in_ready,
  input  logic                     add_rs_full,
  input  logic                     mul_rs_full,
  output logic                     add_valid,
  output logic [4*FIELD_W-1:0]     add_inst,
  output logic                     mul_valid,
  output logic [4*FIELD_W-1:0]     mul_inst,
`ifdef DQU_PERF_COUNTERS_EN
  output logic [15:0]              stall_cycles,
  output logic [15:0]              dual_dispatches,
  output logic [15:0]              dropped_insts,
`endif
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = 4 * FIELD_W;

  logic [IW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr1;
  logic [AW:0]    count;
  logic           push0, push1, h0_v, h1_v;
  logic [IW-1:0]  h0, h1, add_sel, mul_sel;
  logic [FIELD_W-1:0] t0, t1;
  logic           add_fire, mul_fire, drop;
  logic [1:0]     pops, pushes;

  // in_ready looks only at registered occupancy, so a full-ish queue refuses a pair even if it pops
  assign in_ready = (count <= (AW+1)'(DEPTH - 2));
  assign push0    = in_ready & in_valid0 & ~flush;
  assign push1    = push0 & in_valid1;
  assign pushes   = {1'b0, push0} + {1'b0, push1};
  assign q_count  = count;

  assign rd_ptr1 = rd_ptr + AW'(1);
  assign h0      = mem[rd_ptr];
  assign h1      = mem[rd_ptr1];
  assign t0      = h0[IW-1 -: FIELD_W];
  assign t1      = h1[IW-1 -: FIELD_W];
  assign h0_v    = (count != '0);
  assign h1_v    = (count >= (AW+1)'(2));

  always_comb begin
    add_fire = 1'b0;
    mul_fire = 1'b0;
    add_sel  = h0;
    mul_sel  = h0;
    drop     = 1'b0;
    pops     = 2'd0;
    if (h0_v) begin
      if (t0 == ADD_CODE) begin
        if (!add_rs_full) begin
          add_fire = 1'b1;
          pops     = 2'd1;
          if (h1_v && t1 == MUL_CODE && !mul_rs_full) begin
            mul_fire = 1'b1;
            mul_sel  = h1;
            pops     = 2'd2;
          end
        end
      end else if (t0 == MUL_CODE) begin
        if (!mul_rs_full) begin
          mul_fire = 1'b1;
          pops     = 2'd1;
          if (h1_v && t1 == ADD_CODE && !add_rs_full) begin
            add_fire = 1'b1;
            add_sel  = h1;
            pops     = 2'd2;
          end
        end
      end else begin
        // unknown type is popped alone so H1 never overtakes a dropped slot in the same cycle
        drop = 1'b1;
        pops = 2'd1;
      end
    end
  end

  // Storage has no reset: contents are don't-care whenever count says so
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]          <= in_inst0;
    if (push1) mem[wr_ptr + AW'(1)] <= in_inst1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      add_valid <= 1'b0;
      mul_valid <= 1'b0;
      add_inst  <= '0;
      mul_inst  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      add_valid <= 1'b0;
      mul_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(pushes);
      rd_ptr    <= rd_ptr + AW'(pops);
      count     <= count + (AW+1)'(pushes) - (AW+1)'(pops);
      add_valid <= add_fire;
      mul_valid <= mul_fire;
      if (add_fire) add_inst <= add_sel;
      if (mul_fire) mul_inst <= mul_sel;
    end
  end

`ifdef DQU_PERF_COUNTERS_EN
  // Counters survive flush on purpose so software can see cost across flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles    <= '0;
      dual_dispatches <= '0;
      dropped_insts   <= '0;
    end else begin
      if (h0_v && pops == 2'd0 && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (add_fire && mul_fire && !flush && dual_dispatches != 16'hFFFF)
        dual_dispatches <= dual_dispatches + 16'd1;
      if (drop && !flush && dropped_insts != 16'hFFFF)
        dropped_insts <= dropped_insts + 16'd1;
    end
  end
`endif

endmodule
